// File: rtl/pc_unit.sv
// Program-counter unit: fetch address register with fixed-priority redirects
// (stall > ret > jmp > branch > sequential) and a circular return-address stack.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      INC       = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_take,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_err
);
    localparam int unsigned      PW      = $clog2(RAS_DEPTH);
    localparam int unsigned      CW      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

    // Power-up value so simulation starts at the reset vector before any rst edge.
    logic [WIDTH-1:0] r_pc = RESET_VEC;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_err;

    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_ras_top;
    logic [PW-1:0]    w_top_inc;
    logic             w_empty;
    logic             w_full;
    logic             w_push;

    assign w_pc_plus = r_pc + INC_W;
    assign w_ras_top = r_ras[r_top];
    assign w_top_inc = r_top + PW'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    // A ret in the same cycle suppresses the push, so push and pop never coincide.
    assign w_push    = !rst && !stall && !ret && jmp && call;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_ras[w_top_inc] <= w_pc_plus;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_pc    <= RESET_VEC;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (!stall) begin
                if (ret) begin
                    if (!w_empty) begin
                        r_pc    <= w_ras_top;
                        r_top   <= r_top - PW'(1);
                        r_count <= r_count - CW'(1);
                    end else begin
                        r_pc  <= w_pc_plus;
                        r_err <= 1'b1;
                    end
                end else if (jmp) begin
                    r_pc <= jmp_target;
                    if (call) begin
                        r_top <= w_top_inc;
                        // When full, the write above lands on the oldest entry.
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end else if (br_take) begin
                    r_pc <= br_target;
                end else begin
                    r_pc <= w_pc_plus;
                end
            end
        end
    end

    assign pc_out    = r_pc;
    assign pc_plus   = w_pc_plus;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_err   = r_err;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed test-plan steps followed by random redirects,
// all compared against a queue-based model of the fetch address and stack.
module tb_pc_unit;
    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br_take = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_stack[$];
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;

    pc_unit #(.WIDTH(32), .RESET_VEC(32'h0), .INC(4), .RAS_DEPTH(DEPTH)) dut (
        .CLK(CLK), .rst(rst), .stall(stall), .br_take(br_take), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target), .call(call), .ret(ret),
        .pc_out(pc_out), .pc_plus(pc_plus), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_err(ras_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    pc_out, m_pc);
        chk({tag, ".plus"},  pc_plus, m_pc + 32'd4);
        chk({tag, ".empty"}, 32'(ras_empty), 32'(m_stack.size() == 0));
        chk({tag, ".full"},  32'(ras_full), 32'(m_stack.size() == DEPTH));
        chk({tag, ".ovf"},   32'(ras_ovf), 32'(m_ovf));
        chk({tag, ".err"},   32'(ras_err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; br_take = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
        @(posedge CLK);
        #1;
        m_pc = 32'h0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        chk_model("reset");
        rst = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model, then checks after the edge.
    task automatic cycle(input logic st, input logic br, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic c, input logic r);
        logic [31:0] seq;
        stall = st; br_take = br; br_target = bt; jmp = j; jmp_target = jt; call = c; ret = r;
        seq   = m_pc + 32'd4;
        m_err = 1'b0;
        if (!st) begin
            if (r) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc  = seq;
                    m_err = 1'b1;
                end
            end else if (j) begin
                if (c) begin
                    if (m_stack.size() == DEPTH) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_stack.push_back(seq);
                end
                m_pc = jt;
            end else if (br) begin
                m_pc = bt;
            end else begin
                m_pc = seq;
            end
        end
        @(posedge CLK);
        #1;
        chk_model("step");
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic branch(input logic [31:0] t);
        cycle(1'b0, 1'b1, t, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic call_to(input logic [31:0] t);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, t, 1'b1, 1'b0);
    endtask

    task automatic do_ret();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #1;
        chk("powerup.pc", pc_out, 32'h0);
        do_reset();
        chk("rst.pc", pc_out, 32'h0);
        chk("rst.plus", pc_plus, 32'h4);

        idle(); chk("seq1", pc_out, 32'h4);
        idle(); chk("seq2", pc_out, 32'h8);
        idle(); chk("seq3", pc_out, 32'hC);
        chk("seq.empty", 32'(ras_empty), 32'h1);

        branch(32'h10);
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0, 1'b0);
        chk("prio.jmp_over_br", pc_out, 32'h100);
        cycle(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall.hold", pc_out, 32'h100);

        branch(32'h20);
        call_to(32'h400); chk("nest.c1", pc_out, 32'h400);
        call_to(32'h800); chk("nest.c2", pc_out, 32'h800);
        do_ret();         chk("nest.r1", pc_out, 32'h404);
        do_ret();         chk("nest.r2", pc_out, 32'h24);
        chk("nest.empty", 32'(ras_empty), 32'h1);

        do_reset();
        for (int i = 1; i <= 5; i++) call_to(32'(i) * 32'h100);
        chk("ovf.full", 32'(ras_full), 32'h1);
        chk("ovf.flag", 32'(ras_ovf), 32'h1);
        do_ret(); chk("ovf.r1", pc_out, 32'h404);
        do_ret(); chk("ovf.r2", pc_out, 32'h304);
        do_ret(); chk("ovf.r3", pc_out, 32'h204);
        do_ret(); chk("ovf.r4", pc_out, 32'h104);
        chk("ovf.empty", 32'(ras_empty), 32'h1);

        branch(32'h50);
        do_ret();
        chk("eret.pc", pc_out, 32'h54);
        chk("eret.err", 32'(ras_err), 32'h1);
        idle();
        chk("eret.err_clear", 32'(ras_err), 32'h0);

        branch(32'hFFFF_FFFC);
        idle(); chk("wrap.pc", pc_out, 32'h0);
        call_to(32'h600);
        call_to(32'h700);
        chk("mid.depth2", 32'(ras_empty), 32'h0);
        do_reset();
        chk("mid.empty", 32'(ras_empty), 32'h1);
        chk("mid.pc", pc_out, 32'h0);
        chk("mid.ovf", 32'(ras_ovf), 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom,
                      $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 4) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle and upcoming pipelined cores. It is the successor to the plain PC register.
- Holds the fetch address and computes the sequential increment internally.
- Arbitrates stall, return, jump and branch redirects with fixed priority.
- Keeps a small circular return-address stack (RAS) so call/return sequences resolve without a register-file read.

It sits between the next-PC control logic and the instruction memory address port.

## Interface
- WIDTH, 32, address width in bits
- RESET_VEC, 0, value loaded into PC on reset
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- CLK  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- stall  input  1  hold PC and RAS this cycle
- br_take  input  1  take branch to br_target
- br_target  input  WIDTH  branch destination
- jmp  input  1  take jump to jmp_target
- jmp_target  input  WIDTH  jump destination
- call  input  1  with jmp: push pc_out+INC onto RAS
- ret  input  1  pop RAS top into PC
- pc_out  output  WIDTH  current fetch address (registered)
- pc_plus  output  WIDTH  pc_out+INC, combinational
- ras_empty  output  1  RAS count == 0
- ras_full  output  1  RAS count == RAS_DEPTH
- ras_ovf  output  1  sticky: a push occurred while full
- ras_err  output  1  registered one-cycle pulse: ret while empty

## Operation
- State:
  - pc register (WIDTH)
  - RAS array RAS_DEPTH×WIDTH
  - top pointer (log2 RAS_DEPTH bits, wraps)
  - count (0..RAS_DEPTH)
  - ras_ovf flag
  - ras_err flag
- Next-PC priority, evaluated each rising edge:
  - rst: pc=RESET_VEC; count=0; top pointer=0; ras_ovf=0; ras_err=0; RAS contents don't-care.
  - stall: pc, RAS, count and ras_ovf hold. All redirects are ignored, not queued. ras_err=0.
  - ret, count>0: pc=RAS[top]; top pointer decrements (mod RAS_DEPTH); count decrements.
  - ret, count==0: pc=pc_plus; ras_err=1 next cycle; no pointer change.
  - jmp: pc=jmp_target. If call is also asserted, push pc_plus.
  - br_take: pc=br_target.
  - otherwise: pc=pc_plus.
- Push rule:
  - Top pointer increments, then writes.
  - count saturates at RAS_DEPTH.
  - When full, the oldest entry is overwritten (circular) and ras_ovf sets; it stays set until rst.
- call without jmp is ignored.
- ret with jmp/call in the same cycle: ret wins, no push.
- ret beats br_take. jmp beats br_take.
- Arithmetic: pc_plus = (pc_out + INC) mod 2^WIDTH. Wrap at the top of the address space is silent, with no flag.
- ras_err is 0 in every cycle that does not follow an empty-stack ret.
- No target alignment checking is performed; targets load verbatim.

## Timing
- Every redirect has one-cycle latency: inputs sampled at edge N appear on pc_out after edge N.
- pc_plus, ras_empty and ras_full are combinational from registered state. They are valid in the same cycle as pc_out.
- Reset values after an rst edge:
  - pc_out=RESET_VEC
  - pc_plus=RESET_VEC+INC
  - ras_empty=1
  - ras_full=0
  - ras_ovf=0
  - ras_err=0
- Before the first rst, pc initialises to RESET_VEC for simulation.
- rst mid-sequence (e.g. during a call chain) discards all stack contents in the same edge. The stack is empty on the next cycle.
- A push and a pop never happen in the same cycle.
- RAS read of the top entry is combinational from the array. A pop returns the value pushed by the most recent unpopped call, including one pushed on the immediately preceding cycle.

## Test plan
- **Reset and sequential fetch:** apply rst for 1 cycle, then 3 free cycles with RESET_VEC=0, INC=4. Required response: pc_out reads 0, 4, 8, 0xC; ras_empty=1.
- **Priority and stall:**
  - At pc=0x10, assert jmp=1 (jmp_target=0x100) and br_take=1 (br_target=0x200). Required: next pc=0x100.
  - Then assert stall=1 with br_take=1. Required: pc holds at 0x100.
- **Call/return nesting:**
  - At pc=0x20, call+jmp to 0x400.
  - At 0x400, call+jmp to 0x800.
  - ret, then ret.
  - Required pc sequence: 0x400, 0x800, 0x404, 0x24. ras_empty returns to 1.
- **Overflow:**
  - With RAS_DEPTH=4, perform 5 call+jmp from pcs 0x0, 0x100, 0x200, 0x300, 0x400, each jumping to the next.
  - Required: ras_full=1 and ras_ovf=1 after the 5th push.
  - Then 4 rets. Required pcs: 0x404, 0x304, 0x204, 0x104. ras_empty=1 after the 4th.
- **Empty return:** at pc=0x50 with an empty stack, assert ret. Required: pc=0x54 and ras_err=1 for exactly one cycle.
- **Wrap and reset mid-call:**
  - pc=0xFFFFFFFC free-runs. Required: pc becomes 0x00000000.
  - Push 2 entries, then assert rst. Required: ras_empty=1, pc=RESET_VEC, ras_ovf=0.
